layer2_weight_streamer: RTL
===========================

// Module: layer2_weight_streamer
// PURPOSE
//   Read-side sequencer for the layer-2 weight storage. On start, walks NodeSelect over every RELU node,
//   captures each node's 10-weight bank word and streams the weights one per transfer to the layer-2 MAC
//   over a valid/ready handshake, tagging each weight with node/weight indices and last flags.
//   Sits between Layer2WeightStorage (combinational readOut) and the layer-2 accumulator.
// PARAMETERS
//   W            8   bits per weight (= `LAYER_2_WEIGHTS_BIT_WIDTH)
//   NUM_NODES    16  RELU nodes to walk (= `RELU_NODES); must be >= 1
//   IDX_W        4   node index width (= `RELU_INDEX_WIDTH); 2**IDX_W >= NUM_NODES
//   WPN          10  weights per node; fixed by storage word width 10*W
// PORTS
//   clk           in   1       single clock; all state updates on rising edge
//   reset         in   1       synchronous, active-high
//   start         in   1       begin one full pass; sampled only in IDLE
//   abort         in   1       synchronous cancel of a pass in progress
//   nodeSelect    out  IDX_W   drives storage NodeSelect
//   bankData      in   10*W    storage readOut for nodeSelect
//   busy          out  1       high in any state but IDLE; storage writeEnable must be low while high
//   weightOut     out  W       current weight
//   weightValid   out  1       weightOut/indices/flags valid
//   weightReady   in   1       consumer accepts; transfer = weightValid & weightReady
//   nodeIndex     out  IDX_W   node of current weight
//   weightIndex   out  4       0..WPN-1 within node
//   lastWeight    out  1       weightIndex == WPN-1
//   lastNode      out  1       nodeIndex == NUM_NODES-1
//   done          out  1       one-cycle pulse after final transfer of a pass
// BEHAVIOUR
//   Reset: state IDLE; nodeSelect=0, weightOut=0, weightValid=0, indices=0, flags=0, busy=0, done=0.
//   States: IDLE -> SELECT -> STREAM -> (SELECT | DONE) -> IDLE.
//   IDLE:   nodeSelect=0. start=1 -> SELECT with node=0. start outside IDLE ignored.
//   SELECT: nodeSelect=node (registered); one settle cycle; bankData captured into shadow reg at end
//           of cycle; weightIndex<=0; -> STREAM.
//   STREAM: weightValid=1, weightOut=shadow[weightIndex*W +: W] (weight 0 = bits [W-1:0] first).
//           No transfer: all outputs held stable. Transfer with weightIndex<WPN-1: weightIndex+1.
//           Transfer with lastWeight & !lastNode: node+1 -> SELECT (valid low one bubble cycle).
//           Transfer with lastWeight & lastNode -> DONE.
//   DONE:   done=1 for exactly this cycle, weightValid=0 -> IDLE. start here ignored.
//   Latency: start at cycle t -> first weightValid at t+2; pass >= NUM_NODES*(WPN+1)+2 cycles.
//   Shadow reg isolates stream from later bankData changes; bankData only sampled in SELECT.
//   abort (any non-IDLE state): next cycle IDLE, weightValid=0, no done pulse, busy=0; pending weight
//   dropped. abort has priority over transfer in same cycle. abort in IDLE: no effect.
//   reset mid-pass: identical to reset values next cycle; reset beats abort and start.
//   NUM_NODES=1: single SELECT/STREAM, lastNode high throughout.
//   Indices unsigned, no wrap: node never exceeds NUM_NODES-1, weightIndex never exceeds WPN-1.
// STRUCTURE
//   Shared package (GlobalVariables.v): LAYER_2_WEIGHTS_BIT_WIDTH, RELU_NODES, RELU_INDEX_WIDTH,
//   TRUE/FALSE, state encodings ST_IDLE/ST_SELECT/ST_STREAM/ST_DONE (2 bits).
//   One sub-module: layer2_weight_shifter -- shadow reg (10*W), load, weightIndex counter, output mux,
//   lastWeight. Top holds FSM, node counter, handshake and done logic.
// TESTING
//   1 reset, start, bankData node n = weights {n*10+k}, weightReady=1 -> 160 transfers in order
//     (0,0)..(15,9), values n*10+k, done one pulse, exactly 1 bubble between nodes.
//   2 weightReady toggled randomly -> no value/index change while valid&!ready; same 160-item sequence.
//   3 bankData changed mid-STREAM -> streamed values still from capture in SELECT.
//   4 abort during node 5 weight 3 -> next cycle weightValid=0, busy=0, no done; restart gives node 0.
//   5 start pulsed during STREAM and DONE -> ignored; reset mid-pass -> all outputs reset values.
//   6 NUM_NODES=1 build -> 10 transfers, lastNode=1 throughout, lastWeight only on weight 9, done.

Source files
------------

// File: rtl/layer2_weight_streamer_pkg.sv
// Shared widths, boolean constants and sequencer state encodings for the
// layer-2 weight read path.
package layer2_weight_streamer_pkg;

   localparam int LAYER_2_WEIGHTS_BIT_WIDTH = 8;
   localparam int RELU_NODES                = 16;
   localparam int RELU_INDEX_WIDTH          = 4;
   localparam int WEIGHTS_PER_NODE          = 10;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } streamState_t;

endpackage

// File: rtl/layer2_weight_shifter.sv
// Holds a captured bank word and presents one weight at a time, stepping
// through the word as transfers are accepted.
module layer2_weight_shifter
   import layer2_weight_streamer_pkg::*;
#(
   parameter int W   = LAYER_2_WEIGHTS_BIT_WIDTH,
   parameter int WPN = WEIGHTS_PER_NODE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             advance,
   input  logic [WPN*W-1:0] bankData,
   output logic [W-1:0]     weightOut,
   output logic [3:0]       weightIndex,
   output logic             lastWeight
);

   logic [WPN*W-1:0] shadowReg;
   logic [3:0]       idxReg;
   logic [W-1:0]     lanes [WPN];

   generate
      for (genvar gi = 0; gi < WPN; gi++) begin : gLane
         assign lanes[gi] = shadowReg[gi*W +: W];
      end
   endgenerate

   assign weightOut   = lanes[idxReg];
   assign weightIndex = idxReg;
   assign lastWeight  = (idxReg == 4'(WPN-1));

   // Shadow only changes on load, so the stream ignores later storage traffic.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadowReg <= '0;
         idxReg    <= '0;
      end else if (clear) begin
         idxReg    <= '0;
      end else if (load) begin
         shadowReg <= bankData;
         idxReg    <= '0;
      end else if (advance) begin
         idxReg    <= lastWeight ? 4'd0 : idxReg + 4'd1;
      end
   end

endmodule

// File: rtl/layer2_weight_streamer.sv
// Walks every RELU node's weight bank word and streams its weights one per
// valid/ready transfer to the layer-2 MAC.
module layer2_weight_streamer
   import layer2_weight_streamer_pkg::*;
#(
   parameter int W         = LAYER_2_WEIGHTS_BIT_WIDTH,
   parameter int NUM_NODES = RELU_NODES,
   parameter int IDX_W     = RELU_INDEX_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               abort,
   output logic [IDX_W-1:0]                   nodeSelect,
   input  logic [WEIGHTS_PER_NODE*W-1:0]      bankData,
   output logic                               busy,
   output logic [W-1:0]                       weightOut,
   output logic                               weightValid,
   input  logic                               weightReady,
   output logic [IDX_W-1:0]                   nodeIndex,
   output logic [3:0]                         weightIndex,
   output logic                               lastWeight,
   output logic                               lastNode,
   output logic                               done
);

   localparam logic [IDX_W-1:0] LAST_NODE = IDX_W'(NUM_NODES-1);

   streamState_t     stateReg;
   logic [IDX_W-1:0] nodeReg;
   logic             validReg;
   logic             doneReg;
   logic             transfer;
   logic             abortNow;

   assign abortNow    = abort && (stateReg != ST_IDLE);
   assign transfer    = validReg && weightReady;
   assign nodeSelect  = nodeReg;
   assign nodeIndex   = nodeReg;
   assign lastNode    = (nodeReg == LAST_NODE);
   assign busy        = (stateReg != ST_IDLE);
   assign weightValid = validReg;
   assign done        = doneReg;

   layer2_weight_shifter #(
      .W   (W),
      .WPN (WEIGHTS_PER_NODE)
   ) uShifter (
      .clk         (clk),
      .reset       (reset),
      .clear       (abortNow),
      .load        ((stateReg == ST_SELECT) && !abortNow),
      .advance     (transfer && !abortNow),
      .bankData    (bankData),
      .weightOut   (weightOut),
      .weightIndex (weightIndex),
      .lastWeight  (lastWeight)
   );

   // Abort outranks any transfer landing in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || abortNow) begin
         stateReg <= ST_IDLE;
         nodeReg  <= '0;
         validReg <= FALSE;
         doneReg  <= FALSE;
      end else begin
         case (stateReg)
            ST_IDLE: begin
               doneReg <= FALSE;
               nodeReg <= '0;
               if (start) stateReg <= ST_SELECT;
            end
            ST_SELECT: begin
               stateReg <= ST_STREAM;
               validReg <= TRUE;
            end
            ST_STREAM: begin
               if (transfer && lastWeight) begin
                  validReg <= FALSE;
                  if (lastNode) begin
                     stateReg <= ST_DONE;
                     doneReg  <= TRUE;
                  end else begin
                     stateReg <= ST_SELECT;
                     nodeReg  <= nodeReg + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               stateReg <= ST_IDLE;
               doneReg  <= FALSE;
               nodeReg  <= '0;
            end
            default: stateReg <= ST_IDLE;
         endcase
      end
   end

endmodule
